// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU, plus the flag helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL1 = 4'h6;
  localparam logic [3:0] OP_SHR1 = 4'h7;
  localparam logic [3:0] OP_ROL  = 4'h8;
  localparam logic [3:0] OP_ROR  = 4'h9;
  localparam logic [3:0] OP_INC  = 4'hA;
  localparam logic [3:0] OP_DEC  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;
  localparam logic [3:0] OP_PASS = 4'hE;
  localparam logic [3:0] OP_ADC  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement overflow from operand and result sign bits.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    if (is_sub) signed_ovf = (a_msb != b_msb) && (r_msb != a_msb);
    else        signed_ovf = (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic op_updates_carry(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHL1, OP_SHR1, OP_INC, OP_DEC, OP_ADC: op_updates_carry = 1'b1;
      default: op_updates_carry = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_core_if.sv
// Operand/result handshake bundle between the register file, the ALU and writeback.
interface alu_seq_core_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] F;
  logic             z;
  logic             c;
  logic             o;
  logic             G;
  logic             L;
  logic             E;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, F, z, c, o, G, L, E
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, F, z, c, o, G, L, E
  );
endinterface

// File: rtl/alu_shift_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_shift_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] step_sum;

  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // done marks the cycle whose step completes the product; product is final then.
  assign done    = (cnt_q == CW'(1));
  assign product = step_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, A};
      mplier_q <= B;
      cnt_q    <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q    <= step_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked, parametrised ALU with carry chaining and multi-cycle MUL/ROL/ROR.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_core_if.slave bus
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  state_t             state_q, state_d;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   rot_q;
  logic [WIDTH-1:0]   rot_step;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   f_q;
  logic               z_q, c_q, o_q, g_q, l_q, e_q;
  logic               carry_q;

  logic               accept, take, goes_busy, busy_last;
  logic [CW-1:0]      amount;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     add_s, sub_d, inc_s, dec_d;
  logic               cin;
  logic [WIDTH-1:0]   alu_f;
  logic               alu_c, alu_o;

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.F = f_q;
  assign bus.z = z_q;
  assign bus.c = c_q;
  assign bus.o = o_q;
  assign bus.G = g_q;
  assign bus.L = l_q;
  assign bus.E = e_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign take      = bus.out_valid && bus.out_ready;
  assign amount    = {1'b0, bus.B[SW-1:0]};
  assign goes_busy = (bus.op == OP_MUL) ||
                     (((bus.op == OP_ROL) || (bus.op == OP_ROR)) && (amount != '0));
  assign busy_last = (op_q == OP_MUL) ? mul_done : (cnt_q == CW'(1));
  assign mul_start = accept && (bus.op == OP_MUL);

  assign rot_step = (op_q == OP_ROL) ? {rot_q[WIDTH-2:0], rot_q[WIDTH-1]}
                                     : {rot_q[0], rot_q[WIDTH-1:1]};

  alu_shift_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .A      (bus.A),
    .B      (bus.B),
    .done   (mul_done),
    .product(mul_product)
  );

  // Single-cycle datapath, evaluated on the live operands at the accept edge.
  assign cin   = (bus.op == OP_ADC) ? carry_q : 1'b0;
  assign add_s = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, cin};
  assign sub_d = {1'b0, bus.A} - {1'b0, bus.B};
  assign inc_s = {1'b0, bus.A} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_d = {1'b0, bus.A} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_f = bus.A;
    alu_c = 1'b0;
    alu_o = 1'b0;
    unique case (bus.op)
      OP_ADD, OP_ADC: begin
        alu_f = add_s[WIDTH-1:0];
        alu_c = add_s[WIDTH];
        alu_o = signed_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], add_s[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        alu_f = sub_d[WIDTH-1:0];
        alu_c = sub_d[WIDTH];
        alu_o = signed_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], sub_d[WIDTH-1], 1'b1);
      end
      OP_CMP: begin
        alu_c = sub_d[WIDTH];
        alu_o = signed_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], sub_d[WIDTH-1], 1'b1);
      end
      OP_AND:  alu_f = bus.A & bus.B;
      OP_OR:   alu_f = bus.A | bus.B;
      OP_XOR:  alu_f = bus.A ^ bus.B;
      OP_NOT:  alu_f = ~bus.A;
      OP_SHL1: begin
        alu_f = bus.A << 1;
        alu_c = bus.A[WIDTH-1];
      end
      OP_SHR1: begin
        alu_f = bus.A >> 1;
        alu_c = bus.A[0];
      end
      OP_INC: begin
        alu_f = inc_s[WIDTH-1:0];
        alu_c = inc_s[WIDTH];
        alu_o = signed_ovf(bus.A[WIDTH-1], 1'b0, inc_s[WIDTH-1], 1'b0);
      end
      OP_DEC: begin
        alu_f = dec_d[WIDTH-1:0];
        alu_c = dec_d[WIDTH];
        alu_o = signed_ovf(bus.A[WIDTH-1], 1'b0, dec_d[WIDTH-1], 1'b1);
      end
      OP_PASS: alu_f = bus.B;
      OP_ROL, OP_ROR, OP_MUL: begin
        alu_f = bus.A;
      end
      default: alu_f = bus.A;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = goes_busy ? ST_BUSY : ST_DONE;
      ST_BUSY: if (busy_last) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      rot_q   <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      o_q     <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.op;
        rot_q <= bus.A;
        g_q   <= bus.A > bus.B;
        l_q   <= bus.A < bus.B;
        e_q   <= bus.A == bus.B;
        if (bus.op == OP_MUL)                          cnt_q <= CW'(WIDTH);
        else if ((bus.op == OP_ROL) || (bus.op == OP_ROR)) cnt_q <= amount;
        else                                           cnt_q <= '0;
        if (!goes_busy) begin
          f_q <= alu_f;
          z_q <= (alu_f == '0);
          c_q <= alu_c;
          o_q <= alu_o;
        end
      end else if (state_q == ST_BUSY) begin
        rot_q <= rot_step;
        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        // Result registers change only on the final step, so nothing partial is visible.
        if (busy_last) begin
          o_q <= 1'b0;
          if (op_q == OP_MUL) begin
            f_q <= mul_product[WIDTH-1:0];
            z_q <= (mul_product[WIDTH-1:0] == '0);
            c_q <= |mul_product[2*WIDTH-1:WIDTH];
          end else begin
            f_q <= rot_step;
            z_q <= (rot_step == '0);
            c_q <= 1'b0;
          end
        end
      end
      if (take && op_updates_carry(op_q)) carry_q <= c_q;
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at WIDTH=8 and WIDTH=16.
module tb_alu_seq_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_seq_core_if #(.WIDTH(8))  bus8 ();
  alu_seq_core_if #(.WIDTH(16)) bus16 ();

  alu_seq_core #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  alu_seq_core #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  // Present one transaction from IDLE; lat counts cycles from accept edge to out_valid.
  task automatic issue8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
    bus8.op = o; bus8.A = a; bus8.B = b; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue16(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
    bus16.op = o; bus16.A = a; bus16.B = b; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take8();
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic take16();
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus8.in_ready, bus8.out_valid, bus8.z, bus8.c, bus8.o, bus8.G, bus8.L, bus8.E}
        !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_ctl8 got %b want 10000000", {bus8.in_ready, bus8.out_valid,
               bus8.z, bus8.c, bus8.o, bus8.G, bus8.L, bus8.E});
    end
    checks++;
    if (bus8.F !== 8'h00) begin
      errors++; $display("FAIL reset_F8 got %h want 00", bus8.F);
    end
    checks++;
    if ({bus16.in_ready, bus16.out_valid, bus16.F} !== {2'b10, 16'h0000}) begin
      errors++; $display("FAIL reset16 got %b %b %h want 1 0 0000",
                         bus16.in_ready, bus16.out_valid, bus16.F);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    issue8(4'h0, 8'h7F, 8'h01, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL add_lat got %0d want 1", lat); end
    checks++;
    if (bus8.F !== 8'h80) begin errors++; $display("FAIL add_F got %h want 80", bus8.F); end
    checks++;
    if ({bus8.z, bus8.c, bus8.o, bus8.G, bus8.L, bus8.E} !== 6'b001_100) begin
      errors++; $display("FAIL add_flags got %b want 001100",
                         {bus8.z, bus8.c, bus8.o, bus8.G, bus8.L, bus8.E});
    end
    take8();
  endtask

  task automatic test_sub_adc();
    int lat;
    issue8(4'h1, 8'h55, 8'h7F, lat);
    checks++;
    if ({bus8.F, bus8.z, bus8.c, bus8.o, bus8.G, bus8.L, bus8.E} !== {8'hD6, 6'b010_010}) begin
      errors++; $display("FAIL sub got %h %b want d6 010010", bus8.F,
                         {bus8.z, bus8.c, bus8.o, bus8.G, bus8.L, bus8.E});
    end
    take8();
    issue8(4'hF, 8'h01, 8'h01, lat);
    checks++;
    if ({bus8.F, bus8.c, bus8.E} !== {8'h03, 2'b01}) begin
      errors++; $display("FAIL adc got %h c=%b E=%b want 03 c=0 E=1", bus8.F, bus8.c, bus8.E);
    end
    take8();
  endtask

  task automatic test_misc_ops();
    int lat;
    issue8(4'h6, 8'h81, 8'h00, lat);
    checks++;
    if ({bus8.F, bus8.c, bus8.o} !== {8'h02, 2'b10}) begin
      errors++; $display("FAIL shl1 got %h c=%b o=%b want 02 c=1 o=0", bus8.F, bus8.c, bus8.o);
    end
    take8();
    issue8(4'hD, 8'h80, 8'h01, lat);
    checks++;
    if ({bus8.F, bus8.z, bus8.c, bus8.o, bus8.G} !== {8'h80, 4'b0011}) begin
      errors++; $display("FAIL cmp got %h %b want 80 0011", bus8.F,
                         {bus8.z, bus8.c, bus8.o, bus8.G});
    end
    take8();
  endtask

  task automatic test_mul();
    int lat;
    issue8(4'hC, 8'h10, 8'h11, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL mul8_lat got %0d want 9", lat); end
    checks++;
    if ({bus8.F, bus8.z, bus8.c, bus8.o} !== {8'h10, 3'b010}) begin
      errors++; $display("FAIL mul8 got %h %b want 10 010", bus8.F, {bus8.z, bus8.c, bus8.o});
    end
    take8();
    issue16(4'hC, 16'h00FF, 16'h0101, lat);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL mul16_lat got %0d want 17", lat); end
    checks++;
    if ({bus16.F, bus16.c} !== {16'hFFFF, 1'b0}) begin
      errors++; $display("FAIL mul16 got %h c=%b want ffff c=0", bus16.F, bus16.c);
    end
    take16();
  endtask

  task automatic test_rotate();
    int lat;
    issue8(4'h8, 8'hC4, 8'h03, lat);
    checks++;
    if ({lat[7:0], bus8.F, bus8.c, bus8.G} !== {8'd4, 8'h26, 2'b01}) begin
      errors++; $display("FAIL rol3 got lat=%0d F=%h c=%b G=%b want lat=4 F=26 c=0 G=1",
                         lat, bus8.F, bus8.c, bus8.G);
    end
    take8();
    issue8(4'h8, 8'hC4, 8'h08, lat);
    checks++;
    if ({lat[7:0], bus8.F} !== {8'd1, 8'hC4}) begin
      errors++; $display("FAIL rol8 got lat=%0d F=%h want lat=1 F=c4", lat, bus8.F);
    end
    take8();
    issue8(4'h9, 8'hC4, 8'h02, lat);
    checks++;
    if ({lat[7:0], bus8.F} !== {8'd3, 8'h31}) begin
      errors++; $display("FAIL ror2 got lat=%0d F=%h want lat=3 F=31", lat, bus8.F);
    end
    take8();
  endtask

  task automatic test_backpressure();
    int lat;
    issue8(4'h0, 8'h12, 8'h34, lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus8.F, bus8.z, bus8.c, bus8.o, bus8.L, bus8.in_ready, bus8.out_valid}
          !== {8'h46, 6'b000_101}) begin
        errors++; $display("FAIL hold%0d got %h %b want 46 000101", i, bus8.F,
                           {bus8.z, bus8.c, bus8.o, bus8.L, bus8.in_ready, bus8.out_valid});
      end
      @(posedge clk); #1;
    end
    take8();
    checks++;
    if ({bus8.in_ready, bus8.out_valid} !== 2'b10) begin
      errors++; $display("FAIL release got rdy=%b vld=%b want rdy=1 vld=0",
                         bus8.in_ready, bus8.out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    issue8(4'hB, 8'h00, 8'h00, lat);
    checks++;
    if ({bus8.F, bus8.c, bus8.o} !== {8'hFF, 2'b10}) begin
      errors++; $display("FAIL dec0 got %h c=%b o=%b want ff c=1 o=0", bus8.F, bus8.c, bus8.o);
    end
    take8();
    bus8.op = 4'hC; bus8.A = 8'h0F; bus8.B = 8'h0F; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({bus8.in_ready, bus8.out_valid} !== 2'b00) begin
      errors++; $display("FAIL busy got rdy=%b vld=%b want 0 0", bus8.in_ready, bus8.out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus8.in_ready, bus8.out_valid, bus8.F} !== {2'b10, 8'h00}) begin
      errors++; $display("FAIL async_rst got rdy=%b vld=%b F=%h want 1 0 00",
                         bus8.in_ready, bus8.out_valid, bus8.F);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    issue8(4'hF, 8'h10, 8'h20, lat);
    checks++;
    if (bus8.F !== 8'h30) begin
      errors++; $display("FAIL adc_after_rst got %h want 30", bus8.F);
    end
    take8();
    issue8(4'h0, 8'hFF, 8'h01, lat);
    checks++;
    if ({bus8.F, bus8.z, bus8.c, bus8.o} !== {8'h00, 3'b110}) begin
      errors++; $display("FAIL add_wrap got %h %b want 00 110", bus8.F,
                         {bus8.z, bus8.c, bus8.o});
    end
    take8();
  endtask

  initial begin
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;
    bus8.A = '0; bus8.B = '0; bus8.op = '0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus16.A = '0; bus16.B = '0; bus16.op = '0;
    test_reset();
    test_add();
    test_sub_adc();
    test_misc_ops();
    test_mul();
    test_rotate();
    test_backpressure();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, handshaked successor to the 8-bit behavioural ALU. It keeps the 4-bit opcode, the z/c/o status flags and the G/L/E unsigned comparison outputs. It adds a generic data width, valid/ready flow control on both sides, a carry register for chained arithmetic, and multi-cycle operations (shift-add multiply, barrel-free rotate). It sits between the operand register file and the writeback stage, replacing the fixed-width ALU.

## Interface
- WIDTH, default 8: operand/result width; must be ≥ 4 and a power of two.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/opcode presented
- in_ready  out  1  block can accept (high only in IDLE)
- A, B  in  WIDTH  operands
- op  in  4  opcode
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- F  out  WIDTH  result
- z, c, o  out  1  zero, carry/borrow, signed overflow
- G, L, E  out  1  unsigned A>B, A<B, A==B (operands of that transaction)

## Operation
- Accept occurs on a clock edge when in_valid && in_ready. Operands and opcode are captured; inputs are ignored otherwise.
- Opcodes:
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 NOT A
  - 6 SHL1, 7 SHR1 (logical)
  - 8 ROL by B mod WIDTH, 9 ROR by B mod WIDTH
  - A INC A, B DEC A
  - C MUL (low WIDTH bits of A×B)
  - D CMP (F=A, flags only), E PASS B
  - F ADC (A+B+carry_q)
- Flags:
  - z = (F==0) for every op.
  - c: carry-out for ADD/ADC/INC; borrow (1 when A<B unsigned) for SUB/DEC and CMP; shifted-out bit for SHL1/SHR1; 1 for MUL if the high half of the product is nonzero; 0 otherwise.
  - o: two's-complement overflow for ADD/ADC/SUB/INC/DEC/CMP, else 0.
- G/L/E are computed from the captured A,B for every op; exactly one is high.
- carry_q updates to c when each result is accepted (out_valid && out_ready), only for ops 0,1,6,7,A,B,F. It resets to 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → DONE on accept of a single-cycle op, or of ROL/ROR with shift amount 0.
  - IDLE → BUSY on accept of MUL, or ROL/ROR with amount ≠ 0.
  - BUSY → DONE when the iteration counter expires.
  - DONE → IDLE on out_ready.
- BUSY iteration:
  - MUL: one shift-add step per cycle, exactly WIDTH cycles.
  - ROL/ROR: one-bit rotate per cycle, amount = B[log2(WIDTH)-1:0] cycles.
- F and the flags are registered and held stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=1, out_valid=0, F=0, z=c=o=0, G=L=E=0, carry_q=0, state=IDLE, counter=0.
- Latency from accept edge to out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL: WIDTH+1 cycles.
  - ROL/ROR: amount+1 cycles.
- There is no overlap between transactions: in_ready=0 from the accept edge until the edge where the result is taken. Earliest back-to-back is an accept every 2 cycles.
- A result taken on the same edge that in_valid is high does not accept new operands that edge; acceptance happens on the next IDLE cycle.
- ADC uses the carry_q value as of its own accept edge.
- Reset asserted mid-BUSY or in DONE discards the transaction immediately (asynchronously). No partial result is ever presented.
- out_valid never drops without out_ready.

## Structure
- Shared package alu_pkg holds the opcode localparams (OP_ADD … OP_ADC), the state encoding (ST_IDLE/ST_BUSY/ST_DONE), and a function for signed overflow detection.
- Sub-module alu_shift_mul, parameterised by WIDTH, provides the iterative multiplier. Interface: start, A, B → done, product[2*WIDTH-1:0]. The top derives F and c for MUL from that product.
- The iteration counter is $clog2(WIDTH)+1 bits wide.

## Test plan
- Reset then ADD, WIDTH=8: A=0x7F, B=0x01 → after 1 cycle F=0x80, c=0, o=1, z=0, G=1.
- SUB then ADC, WIDTH=8: SUB A=0x55, B=0x7F → F=0xD6, c=1, L=1. Then ADC A=0x01, B=0x01 → F=0x03, proving carry_q=1 was consumed.
- MUL, WIDTH=8: A=0x10, B=0x11 → out_valid exactly 9 cycles after accept, F=0x10, c=1. Also WIDTH=16: 0x00FF×0x0101 → F=0xFFFF, c=0, out_valid after 17 cycles.
- ROL A=0xC4 with B=3 → F=0x26 after 4 cycles. Same op with B=8 → F=0xC4 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles → F and flags stable, in_ready=0. Raising out_ready returns the FSM to IDLE next cycle.
- Assert rst during the 4th MUL cycle → in_ready=1 and out_valid=0 immediately. A following ADD 0xFF+0x01 gives F=0x00, z=1, c=1.
